// File: rtl/mdb_pkg.sv
// rtl/mdb_pkg.sv - shared EN codes, FSM states and destination helper for the bus master
package mdb_pkg;

    localparam logic [1:0] EN_NONE = 2'b00;
    localparam logic [1:0] EN_A    = 2'b01;
    localparam logic [1:0] EN_B    = 2'b10;
    localparam logic [1:0] EN_C    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } mdb_state_e;

    // A destination that selects a real receiver register; anything else is discarded
    function automatic logic dest_is_load(input logic [1:0] dest);
        return (dest == EN_A) || (dest == EN_B) || (dest == EN_C);
    endfunction

endpackage

// File: rtl/mdb_fifo.sv
// rtl/mdb_fifo.sv - request FIFO holding {dest, data} entries for the bus master
module mdb_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Guard both sides so a caller can never overrun or underrun the storage
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage array needs no reset; only entries below count are ever read
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_drop_bus_master.sv
// rtl/multi_drop_bus_master.sv - serialises buffered write requests onto Bus/EN with setup, strobe and hold
module multi_drop_bus_master
    import mdb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] In_Data,
    input  logic [1:0]        In_Dest,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [DATA_W-1:0] Bus,
    output logic              Bus_OE,
    output logic [1:0]        EN,
    output logic              Busy,
    output logic              Drop,
    output logic [7:0]        Tx_Count
);

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYC - 1);

    mdb_state_e        state;
    mdb_state_e        state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [DATA_W-1:0] sh_data;
    logic [DATA_W-1:0] sh_data_nxt;
    logic [1:0]        sh_dest;
    logic [1:0]        sh_dest_nxt;
    logic              ready_q;
    logic              take;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W+1:0] fifo_rdata;
    logic [DATA_W-1:0] bus_nxt;
    logic              oe_nxt;
    logic [1:0]        en_nxt;
    logic              drop_nxt;
    logic [7:0]        tx_nxt;

    // ready_q keeps In_Ready low through reset and for the cycle before the first edge
    assign In_Ready = ready_q && !fifo_full;
    assign push     = In_Valid && In_Ready;
    assign Busy     = (state != ST_IDLE) || !fifo_empty;

    mdb_fifo #(
        .W     (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .Reset (Reset),
        .push  (push),
        .wdata ({In_Dest, In_Data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State, timers, shadow request and all bus-facing outputs update together
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sh_data  <= '0;
            sh_dest  <= EN_NONE;
            ready_q  <= 1'b0;
            Bus      <= '0;
            Bus_OE   <= 1'b0;
            EN       <= EN_NONE;
            Drop     <= 1'b0;
            Tx_Count <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sh_data  <= sh_data_nxt;
            sh_dest  <= sh_dest_nxt;
            ready_q  <= 1'b1;
            Bus      <= bus_nxt;
            Bus_OE   <= oe_nxt;
            EN       <= en_nxt;
            Drop     <= drop_nxt;
            Tx_Count <= tx_nxt;
        end
    end

    // Sequencing: fetch from IDLE or the last HOLD cycle, time SETUP/HOLD with cnt
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sh_data_nxt = sh_data;
        sh_dest_nxt = sh_dest;
        take        = 1'b0;
        pop         = 1'b0;
        drop_nxt    = 1'b0;
        tx_nxt      = Tx_Count;
        case (state)
            ST_IDLE: begin
                take = !fifo_empty;
            end
            ST_SETUP: begin
                if (cnt == 4'd0) state_nxt = ST_STROBE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ST_STROBE: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = HOLD_LOAD;
                tx_nxt    = Tx_Count + 8'd1;
            end
            ST_HOLD: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                    take      = !fifo_empty;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (take) begin
            pop         = 1'b1;
            sh_data_nxt = fifo_rdata[DATA_W-1:0];
            sh_dest_nxt = fifo_rdata[DATA_W+1:DATA_W];
            if (dest_is_load(fifo_rdata[DATA_W+1:DATA_W])) begin
                state_nxt = ST_SETUP;
                cnt_nxt   = SETUP_LOAD;
            end else begin
                drop_nxt  = 1'b1;
            end
        end
    end

    // Bus outputs follow the next state so they are registered with no decode glitches
    always_comb begin
        oe_nxt  = (state_nxt != ST_IDLE);
        bus_nxt = oe_nxt ? sh_data_nxt : '0;
        en_nxt  = (state_nxt == ST_STROBE) ? sh_dest_nxt : EN_NONE;
    end

endmodule
